// File: rtl/if_pkg.sv
// Shared types for the instruction-fetch stage.
//   fetch_state_t : request FSM state (RUN / WAIT / DRAIN)
//   if_entry_t    : one buffered fetch result {pcplus4, inst}
package if_pkg;

    localparam int unsigned IF_PC_SIZE   = 32;
    localparam int unsigned IF_INST_SIZE = 32;
    localparam int unsigned INST_BYTES   = 4;

    typedef enum logic [1:0] {
        RUN   = 2'd0,   // no request outstanding
        WAIT  = 2'd1,   // request outstanding, data kept
        DRAIN = 2'd2    // request outstanding, data discarded
    } fetch_state_t;

    typedef struct packed {
        logic [IF_PC_SIZE-1:0]   pcplus4;
        logic [IF_INST_SIZE-1:0] inst;
    } if_entry_t;

endpackage

// File: rtl/if_skid_fifo.sv
// Two-entry in-order buffer of fetch results. Slot 0 is always the head, so
// the head and valid flag come straight from registers.
//   clk, rst_n    : clock, async active-low reset
//   push_i/din_i  : write one entry
//   pop_i         : consume head (ignored when empty)
//   flush_i       : drop all entries (wins over push/pop)
//   head_o        : head entry, holds last value when empty
//   valid_o       : buffer non-empty
//   count_nxt_c   : occupancy after this edge's push/pop/flush
module if_skid_fifo
    import if_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push_i,
    input  logic       pop_i,
    input  logic       flush_i,
    input  if_entry_t  din_i,
    output if_entry_t  head_o,
    output logic       valid_o,
    output logic [1:0] count_nxt_c
);

    if_entry_t  mem0_q, mem0_d;
    if_entry_t  mem1_q, mem1_d;
    logic [1:0] count_q, count_d;
    logic       valid_q;
    logic       pop_eff;

    assign pop_eff = pop_i && (count_q != 2'd0);

    // Shift-style update: slot 0 is refilled from slot 1 or the input.
    always_comb begin
        mem0_d  = mem0_q;
        mem1_d  = mem1_q;
        count_d = count_q;
        if (flush_i) begin
            count_d = 2'd0;
        end else begin
            case ({push_i, pop_eff})
                2'b10: begin
                    if (count_q == 2'd0) mem0_d = din_i;
                    else                 mem1_d = din_i;
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    if (count_q == 2'd2) mem0_d = mem1_q;
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd2) begin
                        mem0_d = mem1_q;
                        mem1_d = din_i;
                    end else begin
                        mem0_d = din_i;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem0_q  <= '0;
            mem1_q  <= '0;
            count_q <= 2'd0;
            valid_q <= 1'b0;
        end else begin
            mem0_q  <= mem0_d;
            mem1_q  <= mem1_d;
            count_q <= count_d;
            valid_q <= (count_d != 2'd0);
        end
    end

    assign head_o      = mem0_q;
    assign valid_o     = valid_q;
    assign count_nxt_c = count_d;

    // The issue rule guarantees a free slot for every returning fetch.
    push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(push_i && !flush_i && !pop_eff && (count_q == 2'd2)));

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, runs a single-outstanding
// imem handshake, buffers up to two results and handles EX redirects.
//   clk, reset         : clock, async active-low reset
//   imem_req/addr      : registered fetch request, stable until imem_ack
//   imem_ack/rdata     : one-cycle response
//   redirect_valid/pc  : flush and refetch from redirect_pc (word aligned)
//   if_valid/pcplus4/inst : head entry toward IF/ID
//   id_ready           : IF/ID accepts the head entry
module if_fetch_unit
    import if_pkg::*;
#(
    parameter int unsigned         PC_SIZE   = IF_PC_SIZE,
    parameter int unsigned         INST_SIZE = IF_INST_SIZE,
    parameter logic [PC_SIZE-1:0]  RESET_PC  = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 imem_req,
    output logic [PC_SIZE-1:0]   imem_addr,
    input  logic                 imem_ack,
    input  logic [INST_SIZE-1:0] imem_rdata,
    input  logic                 redirect_valid,
    input  logic [PC_SIZE-1:0]   redirect_pc,
    output logic                 if_valid,
    output logic [PC_SIZE-1:0]   if_pcplus4,
    output logic [INST_SIZE-1:0] if_inst,
    input  logic                 id_ready
);

    fetch_state_t       state_q, state_d;
    logic [PC_SIZE-1:0] fetch_pc_q, fetch_pc_d;
    logic [PC_SIZE-1:0] addr_q, addr_d;
    logic               req_q, req_d;

    logic               ack;
    logic               push;
    logic               can_issue;
    logic [1:0]         count_nxt;
    logic [PC_SIZE-1:0] pc_next;
    logic [PC_SIZE-1:0] redirect_pc_aligned;
    if_entry_t          push_entry;
    if_entry_t          head;
    logic               unused_rpc_bits;

    // Acks are only meaningful while a request is outstanding.
    assign ack                 = imem_ack && req_q;
    assign push                = (state_q == WAIT) && ack && !redirect_valid;
    assign can_issue           = (count_nxt <= 2'd1);
    assign pc_next             = fetch_pc_q + PC_SIZE'(INST_BYTES);
    assign redirect_pc_aligned = {redirect_pc[PC_SIZE-1:2], 2'b00};
    assign unused_rpc_bits     = ^redirect_pc[1:0];

    assign push_entry.pcplus4 = IF_PC_SIZE'(addr_q + PC_SIZE'(INST_BYTES));
    assign push_entry.inst    = IF_INST_SIZE'(imem_rdata);

    if_skid_fifo u_fifo (
        .clk         (clk),
        .rst_n       (reset),
        .push_i      (push),
        .pop_i       (id_ready),
        .flush_i     (redirect_valid),
        .din_i       (push_entry),
        .head_o      (head),
        .valid_o     (if_valid),
        .count_nxt_c (count_nxt)
    );

    // Request FSM; redirect has priority over normal issue.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        req_d      = req_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc_aligned;
            if (req_q && !ack) begin
                state_d = DRAIN;
            end else begin
                state_d = RUN;
                req_d   = 1'b0;
            end
        end else begin
            case (state_q)
                RUN: begin
                    if (can_issue) begin
                        state_d    = WAIT;
                        req_d      = 1'b1;
                        addr_d     = fetch_pc_q;
                        fetch_pc_d = pc_next;
                    end
                end
                WAIT: begin
                    if (ack) begin
                        if (can_issue) begin
                            addr_d     = fetch_pc_q;
                            fetch_pc_d = pc_next;
                        end else begin
                            state_d = RUN;
                            req_d   = 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (ack) begin
                        state_d = RUN;
                        req_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = RUN;
                    req_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= RUN;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
            req_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            req_q      <= req_d;
        end
    end

    assign imem_req   = req_q;
    assign imem_addr  = addr_q;
    assign if_pcplus4 = PC_SIZE'(head.pcplus4);
    assign if_inst    = INST_SIZE'(head.inst);

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed vector table, hand-written redirect and
// reset sequences, then random traffic against a queue-based reference model.
// A second instance with RESET_PC=0xFFFFFFFC shares the stimulus.
module tb_if_fetch_unit;

    logic        clk;
    logic        reset;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;

    logic        imem_req,  imem_req2;
    logic [31:0] imem_addr, imem_addr2;
    logic        if_valid,  if_valid2;
    logic [31:0] if_pcplus4, if_pcplus42;
    logic [31:0] if_inst,   if_inst2;

    int n_cmp = 0;
    int n_err = 0;

    if_fetch_unit #(.PC_SIZE(32), .INST_SIZE(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_pcplus4(if_pcplus4), .if_inst(if_inst),
        .id_ready(id_ready)
    );

    if_fetch_unit #(.PC_SIZE(32), .INST_SIZE(32), .RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .reset(reset),
        .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid2), .if_pcplus4(if_pcplus42), .if_inst(if_inst2),
        .id_ready(id_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] inst;
    } ent_t;

    ent_t        mq[$];      // buffered results, oldest first
    bit          m_out;      // request outstanding
    bit          m_drop;     // outstanding result will be discarded
    logic [31:0] m_pc;       // next address to fetch
    logic [31:0] m_addr;     // address of last issued request
    ent_t        m_disp;     // value shown on the IF outputs

    function automatic void model_reset();
        mq.delete();
        m_out  = 1'b0;
        m_drop = 1'b0;
        m_pc   = 32'h0;
        m_addr = 32'h0;
        m_disp = '0;
    endfunction

    task automatic model_edge(input bit ack, input bit rdy, input bit redir,
                              input logic [31:0] rpc, input logic [31:0] rdata);
        bit acked;
        bit may_issue;
        acked = m_out && ack;
        if (rdy && mq.size() > 0) void'(mq.pop_front());
        if (redir) begin
            mq.delete();
            m_pc = {rpc[31:2], 2'b00};
            if (m_out && !acked) begin
                m_drop = 1'b1;
            end else begin
                m_out  = 1'b0;
                m_drop = 1'b0;
            end
        end else begin
            may_issue = !m_out;
            if (acked) begin
                if (!m_drop) begin
                    mq.push_back({m_addr + 32'd4, rdata});
                    may_issue = 1'b1;
                end
                m_out  = 1'b0;
                m_drop = 1'b0;
            end
            if (may_issue && mq.size() <= 1) begin
                m_out  = 1'b1;
                m_addr = m_pc;
                m_pc   = m_pc + 32'd4;
            end
        end
        if (mq.size() > 0) m_disp = mq[0];
    endtask

    // ---------------- helpers ----------------
    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    function automatic void check_model();
        chk("model.req",   {31'd0, imem_req}, {31'd0, m_out});
        chk("model.addr",  imem_addr, m_addr);
        chk("model.valid", {31'd0, if_valid}, {31'd0, (mq.size() > 0)});
        chk("model.pc4",   if_pcplus4, m_disp.pc4);
        chk("model.inst",  if_inst, m_disp.inst);
    endfunction

    // Called at a falling edge; applies inputs across one rising edge.
    task automatic step(input bit ack, input bit rdy, input bit redir, input logic [31:0] rpc);
        logic [31:0] rd;
        rd             = $urandom();
        imem_ack       = ack;
        id_ready       = rdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_rdata     = rd;
        @(posedge clk);
        model_edge(ack, rdy, redir, rpc, rd);
        @(negedge clk);
        check_model();
    endtask

    task automatic do_reset();
        reset          = 1'b0;
        imem_ack       = 1'b0;
        id_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        repeat (2) @(negedge clk);
        model_reset();
        chk("rst.req",    {31'd0, imem_req}, 32'd0);
        chk("rst.addr",   imem_addr, 32'h0);
        chk("rst.valid",  {31'd0, if_valid}, 32'd0);
        chk("rst.pc4",    if_pcplus4, 32'h0);
        chk("rst.inst",   if_inst, 32'h0);
        chk("rst2.addr",  imem_addr2, 32'hFFFF_FFFC);
        chk("rst2.req",   {31'd0, imem_req2}, 32'd0);
        reset = 1'b1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          rst;
        bit          ack;
        bit          rdy;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_valid;
        logic [31:0] e_pc4;
        logic [31:0] e2_addr;
        logic [31:0] e2_pc4;
    } vec_t;

    vec_t tbl[16];

    initial begin
        reset          = 1'b1;
        imem_ack       = 1'b0;
        imem_rdata     = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        id_ready       = 1'b0;
        #2;

        // rst ack rdy | req addr valid pc4 | addr2 pc4_2
        // steady streaming
        tbl[0]  = '{1, 0, 1, 1, 32'h0,  0, 32'h0,  32'hFFFF_FFFC, 32'h0};
        tbl[1]  = '{0, 1, 1, 1, 32'h4,  1, 32'h4,  32'h0, 32'h0};
        tbl[2]  = '{0, 1, 1, 1, 32'h8,  1, 32'h8,  32'h4, 32'h4};
        tbl[3]  = '{0, 1, 1, 1, 32'hC,  1, 32'hC,  32'h8, 32'h8};
        // backpressure, then a 3-cycle ack delay
        tbl[4]  = '{1, 0, 0, 1, 32'h0,  0, 32'h0,  32'hFFFF_FFFC, 32'h0};
        tbl[5]  = '{0, 1, 0, 1, 32'h4,  1, 32'h4,  32'h0, 32'h0};
        tbl[6]  = '{0, 1, 0, 0, 32'h4,  1, 32'h4,  32'h0, 32'h0};
        tbl[7]  = '{0, 0, 0, 0, 32'h4,  1, 32'h4,  32'h0, 32'h0};
        tbl[8]  = '{0, 1, 0, 0, 32'h4,  1, 32'h4,  32'h0, 32'h0};
        tbl[9]  = '{0, 0, 0, 0, 32'h4,  1, 32'h4,  32'h0, 32'h0};
        tbl[10] = '{0, 0, 1, 1, 32'h8,  1, 32'h8,  32'h4, 32'h4};
        tbl[11] = '{0, 0, 1, 1, 32'h8,  0, 32'h8,  32'h4, 32'h4};
        tbl[12] = '{0, 0, 1, 1, 32'h8,  0, 32'h8,  32'h4, 32'h4};
        tbl[13] = '{0, 0, 1, 1, 32'h8,  0, 32'h8,  32'h4, 32'h4};
        tbl[14] = '{0, 1, 1, 1, 32'hC,  1, 32'hC,  32'h8, 32'h8};
        tbl[15] = '{0, 1, 1, 1, 32'h10, 1, 32'h10, 32'hC, 32'hC};

        for (int i = 0; i < 16; i++) begin
            if (tbl[i].rst) do_reset();
            step(tbl[i].ack, tbl[i].rdy, 1'b0, 32'h0);
            chk($sformatf("vec%0d.req", i),   {31'd0, imem_req}, {31'd0, tbl[i].e_req});
            chk($sformatf("vec%0d.addr", i),  imem_addr, tbl[i].e_addr);
            chk($sformatf("vec%0d.valid", i), {31'd0, if_valid}, {31'd0, tbl[i].e_valid});
            chk($sformatf("vec%0d.pc4", i),   if_pcplus4, tbl[i].e_pc4);
            chk($sformatf("vec%0d.addr2", i), imem_addr2, tbl[i].e2_addr);
            chk($sformatf("vec%0d.pc4_2", i), if_pcplus42, tbl[i].e2_pc4);
        end

        // Redirect to 0x103 while the fetch of 0x10 is outstanding.
        do_reset();
        step(0, 1, 0, 32'h0);
        repeat (4) step(1, 1, 0, 32'h0);
        chk("redirA.pre_addr", imem_addr, 32'h10);
        step(0, 1, 1, 32'h103);
        chk("redirA.hold_req",  {31'd0, imem_req}, 32'd1);
        chk("redirA.hold_addr", imem_addr, 32'h10);
        chk("redirA.flushed",   {31'd0, if_valid}, 32'd0);
        step(0, 1, 0, 32'h0);
        step(1, 1, 0, 32'h0);
        chk("redirA.drop_valid", {31'd0, if_valid}, 32'd0);
        chk("redirA.drop_req",   {31'd0, imem_req}, 32'd0);
        step(0, 1, 0, 32'h0);
        chk("redirA.new_addr", imem_addr, 32'h100);
        step(1, 1, 0, 32'h0);
        chk("redirA.first_pc4", if_pcplus4, 32'h104);

        // Redirect on the same edge as an ack with one entry already buffered.
        do_reset();
        step(0, 0, 0, 32'h0);
        step(1, 0, 0, 32'h0);
        step(1, 0, 1, 32'h200);
        chk("redirB.valid", {31'd0, if_valid}, 32'd0);
        chk("redirB.req",   {31'd0, imem_req}, 32'd0);
        step(0, 1, 0, 32'h0);
        chk("redirB.addr", imem_addr, 32'h200);
        step(1, 1, 0, 32'h0);
        chk("redirB.pc4", if_pcplus4, 32'h204);

        // Wrap-around fetch via redirect to the last word.
        step(0, 1, 1, 32'hFFFF_FFFF);
        step(1, 1, 0, 32'h0);
        step(0, 1, 0, 32'h0);
        chk("wrap.addr", imem_addr, 32'hFFFF_FFFC);
        step(1, 1, 0, 32'h0);
        chk("wrap.pc4",  if_pcplus4, 32'h0);
        chk("wrap.next", imem_addr, 32'h0);

        // Reset asserted mid-request: outputs return to reset values at once.
        chk("arst.pre_req", {31'd0, imem_req}, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("arst.req",    {31'd0, imem_req}, 32'd0);
        chk("arst.addr",   imem_addr, 32'h0);
        chk("arst.valid",  {31'd0, if_valid}, 32'd0);
        chk("arst.pc4",    if_pcplus4, 32'h0);
        chk("arst.inst",   if_inst, 32'h0);
        chk("arst2.addr",  imem_addr2, 32'hFFFF_FFFC);
        chk("arst2.valid", {31'd0, if_valid2}, 32'd0);
        @(negedge clk);

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            bit          a, r, rd;
            logic [31:0] tgt;
            a   = ($urandom_range(0, 9) < 6);
            r   = ($urandom_range(0, 9) < 7);
            rd  = ($urandom_range(0, 11) == 0);
            tgt = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : $urandom();
            step(a, r, rd, tgt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t exceeds limit", $time);
        $fatal(1);
    end

endmodule
